// File: rtl/btb_predictor.sv
//------------------------------------------------------------------------------
// Module      : btb_predictor
// Description : Direct-mapped, tagged fetch-stage branch target buffer with
//               2-bit direction counters and a saturating mispredict counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btb_predictor #(
    parameter int ENTRIES    = 8,
    parameter int INDEX_BITS = 3,
    parameter int COUNT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        predicted_taken,
    output logic [31:0] predicted_target,
    output logic [31:0] next_pc,
    input  logic        modify_pc,
    input  logic [31:0] update_pc,
    input  logic        update_btb,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] jump_addr,
    output logic [31:0] mispredict_count
);

    localparam int         c_TAG_BITS = 30 - INDEX_BITS;
    localparam logic [1:0] c_SNT      = 2'b00;
    localparam logic [1:0] c_WNT      = 2'b01;
    localparam logic [1:0] c_ST       = 2'b10;
    localparam logic [1:0] c_WT       = 2'b11;

    logic                  r_valid  [ENTRIES];
    logic [c_TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]           r_target [ENTRIES];
    logic [1:0]            r_state  [ENTRIES];
    logic [COUNT_BITS-1:0] r_count;

    logic [INDEX_BITS-1:0] w_fetch_idx;
    logic [c_TAG_BITS-1:0] w_fetch_tag;
    logic [INDEX_BITS-1:0] w_ex_idx;
    logic [c_TAG_BITS-1:0] w_ex_tag;
    logic                  w_fetch_hit;
    logic                  w_ex_hit;
    logic [1:0]            w_ex_next_state;
    logic                  w_unused;

    assign w_fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign w_fetch_tag = fetch_pc[31:INDEX_BITS+2];
    assign w_ex_idx    = ex_pc[INDEX_BITS+1:2];
    assign w_ex_tag    = ex_pc[31:INDEX_BITS+2];
    assign w_unused    = ^{fetch_pc[1:0], ex_pc[1:0]};

    // Lookup reads the pre-edge table contents; no bypass from training.
    assign w_fetch_hit      = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    assign predicted_taken  = w_fetch_hit && r_state[w_fetch_idx][1];
    assign predicted_target = w_fetch_hit ? r_target[w_fetch_idx] : 32'h0;

    always_comb begin
        next_pc = fetch_pc + 32'd4;
        if (modify_pc) begin
            next_pc = update_pc;
        end else if (predicted_taken) begin
            next_pc = predicted_target;
        end
    end

    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    // Counter walk: SNT <-> WNT <-> WT <-> ST, saturating at both ends.
    always_comb begin
        w_ex_next_state = r_state[w_ex_idx];
        case (r_state[w_ex_idx])
            c_SNT: w_ex_next_state = ex_taken ? c_WNT : c_SNT;
            c_WNT: w_ex_next_state = ex_taken ? c_WT  : c_SNT;
            c_WT:  w_ex_next_state = ex_taken ? c_ST  : c_WNT;
            c_ST:  w_ex_next_state = ex_taken ? c_ST  : c_WT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_state[i]  <= c_SNT;
            end
        end else if (update_btb) begin
            if (w_ex_hit) begin
                r_state[w_ex_idx] <= w_ex_next_state;
                if (ex_taken) begin
                    r_target[w_ex_idx] <= jump_addr;
                end
            end else if (ex_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= jump_addr;
                r_state[w_ex_idx]  <= c_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (modify_pc && (r_count != {COUNT_BITS{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (COUNT_BITS < 32) begin : g_cnt_ext
            assign mispredict_count = {{(32-COUNT_BITS){1'b0}}, r_count};
        end else begin : g_cnt_full
            assign mispredict_count = r_count[31:0];
        end
    endgenerate

endmodule

`default_nettype wire
